// File: rtl/addsub_nibble_serial_ctrl.sv
// addsub_nibble_serial_ctrl
//   Runs a WIDTH-bit add/subtract through a single 4-bit ripple slice, one nibble
//   per clock, LSB nibble first, carrying between nibbles in a register.
//   Accepts work over a valid/ready request port and presents the result over a
//   valid/ready result port.
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid_i / in_ready_o request handshake; in_ready_o is high only when idle
//   op_sub_i                0: a + b, 1: a - b
//   a_i, b_i                WIDTH-bit operands
//   out_valid_o/out_ready_i result handshake
//   result_o                a +/- b modulo 2^WIDTH
//   cout_o                  carry out of the MSB (for subtract, 1 = no borrow)
//   ovf_o                   signed two's-complement overflow
//   zero_o                  result is zero
//   busy_o                  an operation is in flight or waiting to be taken
module addsub_nibble_serial_ctrl #(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned Width  = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             op_sub_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [Width-1:0] a_q;
  logic [Width-1:0] b_q;        // already inverted for subtraction
  logic             carry_q;
  logic [IdxW-1:0]  idx_q;
  logic [Width-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  // Nibble slice datapath
  logic [IdxW+1:0]  bit_base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       sum_nib;
  logic [4:0]       carry_chain;
  logic [Width-1:0] result_nxt;
  logic             last_nib;

  always_comb begin
    bit_base       = {idx_q, 2'b00};
    a_nib          = a_q[bit_base +: 4];
    b_nib          = b_q[bit_base +: 4];
    carry_chain    = '0;
    carry_chain[0] = carry_q;
    sum_nib        = '0;
    // Four full-adder cells in ripple
    for (int i = 0; i < 4; i++) begin
      sum_nib[i]       = a_nib[i] ^ b_nib[i] ^ carry_chain[i];
      carry_chain[i+1] = (a_nib[i] & b_nib[i]) | (carry_chain[i] & (a_nib[i] ^ b_nib[i]));
    end
    result_nxt           = result_q;
    result_nxt[bit_base +: 4] = sum_nib;
    last_nib             = (idx_q == LastIdx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            a_q     <= a_i;
            b_q     <= op_sub_i ? ~b_i : b_i;
            carry_q <= op_sub_i;  // the +1 of two's-complement subtraction
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          result_q <= result_nxt;
          carry_q  <= carry_chain[4];
          if (last_nib) begin
            cout_q  <= carry_chain[4];
            ovf_q   <= (a_nib[3] ~^ b_nib[3]) & (sum_nib[3] ^ a_nib[3]);
            zero_q  <= (result_nxt == '0);
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign result_o    = result_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_addsub_nibble_serial_ctrl.sv
module tb_addsub_nibble_serial_ctrl;

  localparam int unsigned Nib = 4;
  localparam int unsigned W   = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         busy;

  int checks;
  int errors;
  int cycle;

  addsub_nibble_serial_ctrl #(.NIBBLES(Nib)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_sub_i   (op_sub),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .cout_o     (cout),
    .ovf_o      (ovf),
    .zero_o     (zero),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until idle, then accept one operation and check the result.
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sub, input logic [W-1:0] exp_res, input logic exp_cout,
                        input logic exp_ovf, input logic exp_zero);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_wait: in_ready=%b required 1", name, in_ready);
    end
    a = av; b = bv; op_sub = sub; in_valid = 1'b1;
    tick();                     // accepting edge
    in_valid = 1'b0;
    a = ~av; b = av ^ bv; op_sub = ~sub;  // operands may change after accept
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++;
    if (n !== Nib) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, n, Nib);
    end
    checks++;
    if ({result, cout, ovf, zero} !== {exp_res, exp_cout, exp_ovf, exp_zero}) begin
      errors++;
      $display("FAIL %s fields: result=%h cout=%b ovf=%b zero=%b required %h %b %b %b",
               name, result, cout, ovf, zero, exp_res, exp_cout, exp_ovf, exp_zero);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1", name, out_valid,
               in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, result, cout, ovf, zero} !== {3'b100, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b res=%h c=%b o=%b z=%b required 1 0 0 0000 0 0 0",
               in_ready, out_valid, busy, result, cout, ovf, zero);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    run_op("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("sub_5a5a_5a5a", 16'h5A5A, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    run_op("sub_0003_0005", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    int n;
    a = 16'h1111; b = 16'h2222; op_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      a = 16'h0F0F + 16'(i); b = 16'h7777;
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h3333 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_%0d: vld=%b res=%h rdy=%b busy=%b required 1 3333 0 1",
                 i, out_valid, result, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: vld=%b busy=%b rdy=%b required 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    a = 16'h1234; b = 16'h1111; op_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();                     // nibbles 0 and 1 done; nibble 2 next
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, result, cout, ovf, zero} !== {3'b100, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL mid_run_reset: rdy=%b vld=%b busy=%b res=%h c=%b o=%b z=%b required 1 0 0 0000 0 0 0",
               in_ready, out_valid, busy, result, cout, ovf, zero);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_run_after: vld=%b busy=%b required 0 0", out_valid, busy);
    end
    run_op("post_reset_add", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va   [3];
    logic [W-1:0] vb   [3];
    logic         vs   [3];
    logic [W-1:0] vexp [3];
    int n;
    int acc_cycle;
    int prev_acc;
    va[0] = 16'h0100; vb[0] = 16'h0200; vs[0] = 1'b0; vexp[0] = 16'h0300;
    va[1] = 16'h0FFF; vb[1] = 16'h0001; vs[1] = 1'b1; vexp[1] = 16'h0FFE;
    va[2] = 16'hABCD; vb[2] = 16'h1111; vs[2] = 1'b0; vexp[2] = 16'hBCDE;
    prev_acc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      a = va[k]; b = vb[k]; op_sub = vs[k];
      acc_cycle = cycle;
      tick();
      if (k > 0) begin
        checks++;
        if (acc_cycle - prev_acc !== Nib + 2) begin
          errors++;
          $display("FAIL b2b_spacing_%0d: got %0d cycles required %0d", k, acc_cycle - prev_acc,
                   Nib + 2);
        end
      end
      prev_acc = acc_cycle;
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      checks++;
      if (out_valid !== 1'b1 || result !== vexp[k]) begin
        errors++;
        $display("FAIL b2b_result_%0d: vld=%b res=%h required 1 %h", k, out_valid, result,
                 vexp[k]);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; cycle = 0;
    rst_n = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    #2;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
